// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice built from two half adders,
// stepped LSB first over WIDTH bits with a registered carry.
//
// half_adder ports: a, b -> s (a^b), c (a&b).
// serial_adder_ctrl ports:
//   CLK, RST_N (async, active-low)
//   START, A, B, CIN  : request and operands, sampled when READY=1
//   READY, BUSY, DONE : one-hot status decoded from the state register
//   S, COUT           : registered result, updated on completion only

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic ha0_s, ha0_c;
    logic sum_bit, ha1_c;
    logic slice_cout;
    logic last_bit;

    half_adder u_ha0 (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (sum_bit),
        .c (ha1_c)
    );

    assign slice_cout = ha0_c | ha1_c;
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so that after WIDTH steps
                // the first (LSB) sum bit has reached bit 0.
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = slice_cout;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    s_d     = res_d;
                    cout_d  = slice_cout;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign READY = (state_q == IDLE);
    assign BUSY  = (state_q == RUN);
    assign DONE  = (state_q == FIN);
    assign S     = s_q;
    assign COUT  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl at WIDTH=8 and WIDTH=2 side by side.
// Cycle-level reference model plus directed literal checks.

module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       rdy8, bsy8, dn8, co8;
    logic [7:0] s8;
    logic       rdy2, bsy2, dn2, co2;
    logic [1:0] s2;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start),
        .A(a), .B(b), .CIN(cin),
        .READY(rdy8), .BUSY(bsy8), .DONE(dn8),
        .S(s8), .COUT(co8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start),
        .A(a[1:0]), .B(b[1:0]), .CIN(cin),
        .READY(rdy2), .BUSY(bsy2), .DONE(dn2),
        .S(s2), .COUT(co2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: k = edges since accept (-1 when idle); held = last {COUT,S}.
    int          k[2]    = '{-1, -1};
    logic [32:0] expv[2] = '{33'd0, 33'd0};
    logic [32:0] held[2] = '{33'd0, 33'd0};
    int          nacc[2] = '{0, 0};

    task automatic mstep(int id, int w);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        if (k[id] < 0) begin
            if (start) begin
                expv[id] = (33'(a) & m) + (33'(b) & m) + 33'(cin);
                k[id] = 0;
                nacc[id]++;
            end
        end else if (k[id] == w) begin
            k[id] = -1;
        end else begin
            k[id]++;
            if (k[id] == w) held[id] = expv[id];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k[0] = -1; k[1] = -1;
            held[0] = '0; held[1] = '0;
        end else begin
            mstep(0, 8);
            mstep(1, 2);
        end
    end

    task automatic mcheck(int id, int w, logic r, logic bz, logic d,
                          logic [31:0] sv, logic co);
        logic [32:0] m;
        logic er, eb, ed;
        m  = (33'd1 << w) - 33'd1;
        er = (k[id] < 0);
        eb = (k[id] >= 0) && (k[id] < w);
        ed = (k[id] == w);
        chk($sformatf("ctl_w%0d", w), {r, bz, d}, {er, eb, ed});
        chk($sformatf("onehot_w%0d", w), $onehot({r, bz, d}), 1);
        chk($sformatf("sum_w%0d", w), sv, held[id] & m);
        chk($sformatf("cout_w%0d", w), co, held[id][w]);
    endtask

    always @(negedge clk) begin
        mcheck(0, 8, rdy8, bsy8, dn8, 32'(s8), co8);
        mcheck(1, 2, rdy2, bsy2, dn2, 32'(s2), co2);
    end

    task automatic count_done(int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dn8) c++;
        end
    endtask

    task automatic wait_ready(string nm);
        int n;
        n = 0;
        while (!rdy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, rdy8, 1);
    endtask

    task automatic op8(string nm, logic [7:0] av, logic [7:0] bv,
                       logic ci, logic [7:0] es, logic ec, bit poke);
        int n, nb, extra;
        wait_ready(nm);
        start = 1'b1; a = av; b = bv; cin = ci;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nb = 0;
        while (!dn8 && n < 30) begin
            if (bsy8) nb++;
            @(negedge clk);
            n++;
            start = poke && (n == 3);
            if (start) a = 8'h55;
        end
        start = 1'b0;
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_busy_cycles"}, nb, 8);
        chk({nm, "_s"}, s8, es);
        chk({nm, "_cout"}, co8, ec);
        if (poke) begin
            count_done(20, extra);
            chk({nm, "_extra_done"}, extra, 0);
        end
    endtask

    initial begin
        int c, last, ndone, n, base8, base2;
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy8, 1);
        chk("rst_busy", bsy8, 0);
        chk("rst_done", dn8, 0);
        chk("rst_s", s8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ready_w2", rdy2, 1);
        rst_n = 1'b1;
        @(negedge clk);

        op8("add0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        chk("w2_s_a", s2, 2'd0);
        chk("w2_cout_a", co2, 1);
        op8("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("addffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("w2_s_b", s2, 2'd3);
        chk("w2_cout_b", co2, 1);
        op8("ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);

        // Abort at bit 4 of a run.
        wait_ready("abort");
        start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", rdy8, 1);
        chk("abort_busy", bsy8, 0);
        chk("abort_done", dn8, 0);
        chk("abort_s", s8, 0);
        chk("abort_cout", co8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, c);
        chk("abort_no_done", c, 0);
        op8("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);

        // START held high, operands changing every cycle.
        start = 1'b1;
        last = -1;
        ndone = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            if (dn8) begin
                ndone++;
                if (last >= 0) chk("held_spacing", cyc - last, 10);
                last = cyc;
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone >= 5, 1);

        // Random sweep for both widths.
        base8 = nacc[0];
        base2 = nacc[1];
        n = 0;
        while ((nacc[0] < base8 + 500 || nacc[1] < base2 + 500) && n < 20000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            n++;
        end
        start = 1'b0;
        chk("sweep_ops_w8", nacc[0] >= base8 + 500, 1);
        chk("sweep_ops_w2", nacc[1] >= base2 + 500, 1);
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that computes a WIDTH-bit sum by sequencing one 1-bit full-adder slice over the operands, LSB first. The slice is two `half_adder` instances plus an OR of their carries. The carry is held in a flip-flop between bit steps. The block gives the design an area-cheap multi-bit adder with a start/done handshake, and owns all operand shifting, carry state and result capture around the gate-level slice.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request a new addition; sampled only while READY=1.
- A  input  WIDTH  operand A; sampled on the accepting edge only.
- B  input  WIDTH  operand B; sampled on the accepting edge only.
- CIN  input  1  carry-in; sampled on the accepting edge only.
- READY  output  1  high in IDLE; block can accept START.
- BUSY  output  1  high in RUN.
- DONE  output  1  single-cycle pulse; S and COUT are updated at the start of this cycle.
- S  output  WIDTH  registered sum, held until the next completion.
- COUT  output  1  registered carry-out, held until the next completion.

## Operation

- Clock and reset: one clock (CLK). RST_N is asynchronous, active-low.
- States: IDLE, RUN, FIN. Encoding is free; the state register is cleared by RST_N.
- Reset values:
  - state=IDLE, READY=1, BUSY=0, DONE=0, S=0, COUT=0.
  - Shift registers, carry flop and bit counter all 0.
- IDLE, START=1 at a rising edge (accept):
  - Load A and B into the operand shift registers.
  - Load the carry flop with CIN.
  - Clear the bit counter.
  - Go to RUN.
- IDLE, START=0: remain in IDLE.
- RUN, each edge:
  - Slice inputs are a_sh[0], b_sh[0] and the carry flop.
  - Slice sum bit enters the MSB of the result shift register; the result register shifts right.
  - Carry flop takes the slice carry-out.
  - a_sh and b_sh shift right by one.
  - Counter increments.
- RUN, edge at which counter == WIDTH-1 (last bit):
  - Perform the normal RUN update.
  - Copy the completed result (including this bit) into S.
  - Copy the final carry into COUT.
  - Go to FIN.
- FIN: DONE=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- START is ignored in RUN and FIN; it is not queued. A, B and CIN may change freely after acceptance.
- S and COUT never change except on the completion edge or on reset. They do not show partial results during RUN.
- Arithmetic: {COUT,S} = A + B + CIN, modulo 2^(WIDTH+1). Bit counter width is clog2(WIDTH).
- Reset mid-operation: everything returns immediately (asynchronously) to reset values. The in-flight result is discarded. No DONE pulse is issued for the aborted operation.

## Timing

- Edge numbering: accepting edge is e0; RUN edges are e1..eWIDTH.
- S and COUT become valid after eWIDTH. DONE is high between eWIDTH and eWIDTH+1.
- READY returns to 1 after eWIDTH+1.
- Latency: START accept to DONE high is WIDTH+1 cycles.
- Throughput: with START held high, one operation every WIDTH+2 cycles. Each new accept occurs at the first edge with READY=1.
- All outputs are registered or decoded directly from the state register. No combinational path exists from inputs to outputs.
- Exactly one of READY, BUSY and DONE is high in every cycle out of reset.

## Test plan

- WIDTH=8, A=0x0F, B=0x01, CIN=0:
  - DONE pulses 9 cycles after accept.
  - S=0x10, COUT=0.
  - BUSY high for exactly 8 cycles.
- A=0xFF, B=0x01, CIN=0 gives S=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 gives S=0xFF, COUT=1. Checks full carry propagation and CIN use.
- Pulse START again with A=0x55 during RUN of an op with A=0x12, B=0x34:
  - The second START is ignored.
  - S=0x46, COUT=0.
  - Exactly one DONE pulse.
- Hold START=1 continuously with operands changing every cycle:
  - Accepts occur every 10 cycles.
  - Each S equals the sum of the operands present on its accepting edge.
  - S stays stable between DONE pulses.
- Assert RST_N=0 for one cycle during bit 4 of a RUN:
  - Immediately READY=1, BUSY=0, DONE=0, S=0, COUT=0.
  - No DONE for the aborted op.
  - A subsequent op 0x80+0x80 gives S=0x00, COUT=1.
- Randomized sweep of 500 ops at WIDTH=8 and WIDTH=2 against a reference model of A+B+CIN. Also check on every cycle that READY, BUSY and DONE are mutually exclusive.
